// File: rtl/store_narrow_pkg.sv
// rtl/store_narrow_pkg.sv - shared widths and FSM encoding for the store narrowing unit
package store_narrow_pkg;

  localparam int SN_WORD_W = 16;
  localparam int SN_BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } state_t;

endpackage

// File: rtl/store_narrow_byte_lane_sel.sv
// rtl/store_narrow_byte_lane_sel.sv - picks the beat byte from the captured store word
// Endianness: STORE_NARROW_BIG_ENDIAN_EN selects big-endian word order.
module byte_lane_sel #(
  parameter int WORD_W = 16,
  parameter int BYTE_W = 8
) (
  input  logic [WORD_W-1:0] word,
  input  logic              beat,
  input  logic              is_byte,
  output logic [BYTE_W-1:0] lane
);

  logic take_hi;

  // Store-byte always emits the low byte, whatever the word order.
`ifdef STORE_NARROW_BIG_ENDIAN_EN
  assign take_hi = !is_byte && !beat;
`else
  assign take_hi = !is_byte && beat;
`endif

  assign lane = take_hi ? word[WORD_W-1 -: BYTE_W] : word[BYTE_W-1:0];

endmodule

// File: rtl/store_narrow.sv
// rtl/store_narrow.sv - narrows a 16-bit store into one or two byte beats for the data memory
// Build option: STORE_NARROW_BIG_ENDIAN_EN (big-endian store-word beat order).
module store_narrow
  import store_narrow_pkg::*;
#(
  parameter int WORD_W = SN_WORD_W,
  parameter int BYTE_W = SN_BYTE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] data_in,
  input  logic [WORD_W-1:0] addr_in,
  input  logic              in_byte,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] data_out,
  output logic [WORD_W-1:0] addr_out,
  output logic              out_last,
  output logic              busy
);

  state_t            state, state_n;
  logic [WORD_W-1:0] cap_data, cap_data_n;
  logic [WORD_W-1:0] cap_addr, cap_addr_n;
  logic              cap_byte, cap_byte_n;
  logic              last_beat, accept;
  logic              out_valid_n, out_last_n;
  logic [BYTE_W-1:0] data_out_n, lane;
  logic [WORD_W-1:0] addr_out_n;

  // A new request may slip in on the edge that retires the final beat.
  assign last_beat = (state == BEAT1) || ((state == BEAT0) && cap_byte);
  assign in_ready  = !rst && ((state == IDLE) || (last_beat && out_ready));
  assign accept    = in_valid && in_ready;

  byte_lane_sel #(
    .WORD_W(WORD_W),
    .BYTE_W(BYTE_W)
  ) u_sel (
    .word   (cap_data_n),
    .beat   (state_n == BEAT1),
    .is_byte(cap_byte_n),
    .lane   (lane)
  );

  always_comb begin
    state_n    = state;
    cap_data_n = cap_data;
    cap_addr_n = cap_addr;
    cap_byte_n = cap_byte;
    case (state)
      IDLE:  if (accept) state_n = BEAT0;
      BEAT0: if (out_ready) state_n = cap_byte ? (accept ? BEAT0 : IDLE) : BEAT1;
      BEAT1: if (out_ready) state_n = accept ? BEAT0 : IDLE;
      default: state_n = IDLE;
    endcase
    if (accept) begin
      cap_data_n = data_in;
      cap_addr_n = addr_in;
      cap_byte_n = in_byte;
    end

    // Output registers load the view of the state being entered.
    out_valid_n = (state_n != IDLE);
    out_last_n  = (state_n == BEAT1) || ((state_n == BEAT0) && cap_byte_n);
    data_out_n  = out_valid_n ? lane : '0;
    case (state_n)
      BEAT0:   addr_out_n = cap_addr_n;
      BEAT1:   addr_out_n = cap_addr_n + {{(WORD_W-1){1'b0}}, 1'b1};
      default: addr_out_n = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cap_data  <= '0;
      cap_addr  <= '0;
      cap_byte  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      data_out  <= '0;
      addr_out  <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cap_data  <= cap_data_n;
      cap_addr  <= cap_addr_n;
      cap_byte  <= cap_byte_n;
      out_valid <= out_valid_n;
      out_last  <= out_last_n;
      data_out  <= data_out_n;
      addr_out  <= addr_out_n;
      busy      <= (state_n != IDLE);
    end
  end

endmodule
